// File: rtl/multicycle_ctrl.sv
//------------------------------------------------------------------------------
// multicycle_ctrl
//   Moore control FSM for a multicycle core sharing one instruction/data memory
//   (mem_ready handshake). Datapath controls are registered alongside the state.
//   IRWrite/PCWrite in FETCH are the only outputs gated by mem_ready.
//   Optional feature: define MC_INSTRET_EN to include the retired-instruction
//   counter; when undefined, instret is tied to 0.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  op,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        Branch,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUOp,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_JAL    = 4'd10
  } state_t;

  // Moore (state-only) control word; the FETCH strobes are added separately.
  typedef struct packed {
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       pc_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
  } ctrl_t;

  state_t cur_state;
  state_t nxt_state;
  ctrl_t  ctrl_reg;
  logic   illegal_reg;
  logic   bad_op;
  logic   fetch_strobe;

  // Control word for a given state; unlisted fields (and unused codes) are 0.
  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'd2; c.result_src = 2'd2; end
      S_DECODE: begin c.alu_src_a = 2'd1; c.alu_src_b = 2'd1; end
      S_MEMADR: begin c.alu_src_a = 2'd2; c.alu_src_b = 2'd1; end
      S_MEMRD:  begin c.adr_src = 1'b1; c.mem_read = 1'b1; end
      S_MEMWB:  begin c.result_src = 2'd1; c.reg_write = 1'b1; end
      S_MEMWR:  begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      S_EXECR:  begin c.alu_src_a = 2'd2; c.alu_op = 2'd2; end
      S_EXECI:  begin c.alu_src_a = 2'd2; c.alu_src_b = 2'd1; c.alu_op = 2'd2; end
      S_ALUWB:  begin c.reg_write = 1'b1; end
      S_BEQ:    begin c.alu_src_a = 2'd2; c.alu_op = 2'd1; c.branch = 1'b1; end
      S_JAL:    begin c.alu_src_a = 2'd1; c.alu_src_b = 2'd2; c.pc_write = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  // Next-state decode; waiting states hold until the memory reports done.
  always_comb begin
    nxt_state = S_FETCH;
    bad_op    = 1'b0;
    case (cur_state)
      S_FETCH:  nxt_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt_state = S_MEMADR;
          OP_R:         nxt_state = S_EXECR;
          OP_I:         nxt_state = S_EXECI;
          OP_BEQ:       nxt_state = S_BEQ;
          OP_JAL:       nxt_state = S_JAL;
          default: begin
            nxt_state = S_FETCH;
            bad_op    = 1'b1;
          end
        endcase
      end
      S_MEMADR: nxt_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  nxt_state = S_FETCH;
      S_MEMWR:  nxt_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECR:  nxt_state = S_ALUWB;
      S_EXECI:  nxt_state = S_ALUWB;
      S_ALUWB:  nxt_state = S_FETCH;
      S_BEQ:    nxt_state = S_FETCH;
      S_JAL:    nxt_state = S_ALUWB;
      default:  nxt_state = S_FETCH;
    endcase
  end

  // State, registered control word for the upcoming state, and illegal pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state   <= S_FETCH;
      ctrl_reg    <= ctrl_of(S_FETCH);
      illegal_reg <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      ctrl_reg    <= ctrl_of(nxt_state);
      illegal_reg <= bad_op;
    end
  end

  // Instruction fetch completes in the cycle mem_ready is seen; held off in reset.
  assign fetch_strobe = (cur_state == S_FETCH) && mem_ready && rst;

  assign IRWrite   = fetch_strobe;
  assign PCWrite   = ctrl_reg.pc_write | fetch_strobe;
  assign Branch    = ctrl_reg.branch;
  assign AdrSrc    = ctrl_reg.adr_src;
  assign MemRead   = ctrl_reg.mem_read;
  assign MemWrite  = ctrl_reg.mem_write;
  assign RegWrite  = ctrl_reg.reg_write;
  assign ALUSrcA   = ctrl_reg.alu_src_a;
  assign ALUSrcB   = ctrl_reg.alu_src_b;
  assign ResultSrc = ctrl_reg.result_src;
  assign ALUOp     = ctrl_reg.alu_op;
  assign state     = cur_state;
  assign illegal   = illegal_reg;

`ifdef MC_INSTRET_EN
  logic        retire;
  logic [31:0] instret_cnt;

  // An instruction retires when a completing state hands back to FETCH;
  // illegal-opcode returns come from DECODE and are therefore not counted.
  assign retire = (nxt_state == S_FETCH) &&
                  ((cur_state == S_MEMWB) || (cur_state == S_MEMWR) ||
                   (cur_state == S_ALUWB) || (cur_state == S_BEQ));

  // Free-running retired-instruction counter, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_cnt <= '0;
    end else if (retire) begin
      instret_cnt <= instret_cnt + 32'd1;
    end
  end

  assign instret = instret_cnt;
`else
  assign instret = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
//------------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Scoreboard bench: the stimulus process walks each instruction through the
//   state sequence its class requires, pushing one expected record per cycle;
//   a negedge monitor pops and compares state, controls, illegal and instret.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_ctrl;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BEQ    = 4'd9;
  localparam logic [3:0] S_JAL    = 4'd10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  op = 7'd0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, Branch, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] instret;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .Branch(Branch), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp),
    .state(state), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic        mr;
    logic        ill;
    logic [31:0] ret;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_ret = 32'd0;
  logic        ill_pend = 1'b0;
  logic        wrap_req = 1'b0;
  logic [14:0] dut_vec;

  assign dut_vec = {PCWrite, Branch, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
                    ALUSrcA, ALUSrcB, ResultSrc, ALUOp};

  // Output table straight from the state descriptions; mr gates the fetch strobes.
  function automatic logic [14:0] spec_outs(input logic [3:0] s, input logic mr);
    logic pcw, br, irw, adr, mrd, mwr, rw;
    logic [1:0] a, b, res, aop;
    {pcw, br, irw, adr, mrd, mwr, rw} = 7'd0;
    a = 2'd0; b = 2'd0; res = 2'd0; aop = 2'd0;
    case (s)
      S_FETCH:  begin mrd = 1'b1; b = 2'd2; res = 2'd2; irw = mr; pcw = mr; end
      S_DECODE: begin a = 2'd1; b = 2'd1; end
      S_MEMADR: begin a = 2'd2; b = 2'd1; end
      S_MEMRD:  begin adr = 1'b1; mrd = 1'b1; end
      S_MEMWB:  begin res = 2'd1; rw = 1'b1; end
      S_MEMWR:  begin adr = 1'b1; mwr = 1'b1; end
      S_EXECR:  begin a = 2'd2; aop = 2'd2; end
      S_EXECI:  begin a = 2'd2; b = 2'd1; aop = 2'd2; end
      S_ALUWB:  begin rw = 1'b1; end
      S_BEQ:    begin a = 2'd2; aop = 2'd1; br = 1'b1; end
      S_JAL:    begin a = 2'd1; b = 2'd2; pcw = 1'b1; end
      default:  ;
    endcase
    return {pcw, br, irw, adr, mrd, mwr, rw, a, b, res, aop};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: one expected record per clock, compared mid-cycle.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      check("ctrl{state,outs,illegal}", {44'd0, state, dut_vec, illegal},
            {44'd0, mon_e.st, spec_outs(mon_e.st, mon_e.mr), mon_e.ill});
      check("instret", {32'd0, instret}, {32'd0, mon_e.ret});
    end
  end

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic retire();
`ifdef MC_INSTRET_EN
    model_ret = model_ret + 32'd1;
`endif
  endtask

  // Drive one cycle's inputs and queue what the DUT must show in that cycle.
  task automatic step(input logic [6:0] o, input logic [3:0] st, input logic mr);
    exp_t e;
    @(posedge clk); #1;
    op = o;
    mem_ready = mr;
`ifdef MC_INSTRET_EN
    if (wrap_req) begin
      force dut.instret_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.instret_cnt;
      model_ret = 32'hFFFF_FFFF;
      wrap_req = 1'b0;
    end
`endif
    e.st = st; e.mr = mr; e.ill = ill_pend; e.ret = model_ret;
    ill_pend = 1'b0;
    sbq.push_back(e);
  endtask

  // Reference: state path per instruction class, with fw/mw memory wait cycles.
  task automatic run_instr(input logic [6:0] o, input int fw, input int mw);
    for (int i = 0; i < fw; i++) step(o, S_FETCH, 1'b0);
    step(o, S_FETCH, 1'b1);
    step(o, S_DECODE, rnd_bit());
    case (o)
      OP_LW: begin
        step(o, S_MEMADR, rnd_bit());
        for (int i = 0; i < mw; i++) step(o, S_MEMRD, 1'b0);
        step(o, S_MEMRD, 1'b1);
        step(o, S_MEMWB, rnd_bit());
        retire();
      end
      OP_SW: begin
        step(o, S_MEMADR, rnd_bit());
        for (int i = 0; i < mw; i++) step(o, S_MEMWR, 1'b0);
        step(o, S_MEMWR, 1'b1);
        retire();
      end
      OP_R:   begin step(o, S_EXECR, rnd_bit()); step(o, S_ALUWB, rnd_bit()); retire(); end
      OP_I:   begin step(o, S_EXECI, rnd_bit()); step(o, S_ALUWB, rnd_bit()); retire(); end
      OP_BEQ: begin step(o, S_BEQ, rnd_bit()); retire(); end
      OP_JAL: begin step(o, S_JAL, rnd_bit()); step(o, S_ALUWB, rnd_bit()); retire(); end
      default: ill_pend = 1'b1;
    endcase
  endtask

  function automatic logic [6:0] pick_op();
    logic [6:0] o;
    case ($urandom_range(0, 6))
      0: o = OP_LW;
      1: o = OP_SW;
      2: o = OP_R;
      3: o = OP_I;
      4: o = OP_BEQ;
      5: o = OP_JAL;
      default: begin
        o = 7'($urandom);
        if (o == OP_LW || o == OP_SW || o == OP_R || o == OP_I || o == OP_BEQ || o == OP_JAL)
          o = 7'b0000000;
      end
    endcase
    return o;
  endfunction

  task automatic check_reset_outs(input string tag);
    check({tag, "_state"},   {60'd0, state}, {60'd0, S_FETCH});
    check({tag, "_outs"},    {49'd0, dut_vec}, {49'd0, spec_outs(S_FETCH, 1'b0)});
    check({tag, "_illegal"}, {63'd0, illegal}, 64'd0);
    check({tag, "_instret"}, {32'd0, instret}, 64'd0);
  endtask

  initial begin
    // Reset asserted between edges with mem_ready high: strobes must stay low.
    #2 rst = 1'b0; mem_ready = 1'b1;
    #1 check_reset_outs("reset");
    @(posedge clk); #1;
    check_reset_outs("reset_hold");
    @(negedge clk); #2;
    mem_ready = 1'b0;
    rst = 1'b1;

    // Directed: R-type, lw with waits, sw, illegal, then remaining classes.
    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 3, 2);
    run_instr(OP_SW, 0, 0);
    run_instr(7'b0000000, 0, 0);
    run_instr(OP_I, 1, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_JAL, 2, 0);
    run_instr(OP_SW, 1, 3);

    // Randomized instruction stream with random memory waits.
    for (int n = 0; n < 120; n++)
      run_instr(pick_op(), $urandom_range(0, 3), $urandom_range(0, 3));

    // Counter wrap: preload all-ones, retire one beq, next FETCH must show 0.
    wrap_req = 1'b1;
    run_instr(OP_BEQ, 1, 0);
    run_instr(OP_R, 0, 0);

    // Reset mid-MEMRD wait, asserted between clock edges.
    step(OP_LW, S_FETCH, 1'b1);
    step(OP_LW, S_DECODE, 1'b0);
    step(OP_LW, S_MEMADR, 1'b0);
    step(OP_LW, S_MEMRD, 1'b0);
    @(negedge clk); #2;
    rst = 1'b0;
    #1 check_reset_outs("async_reset");
    model_ret = 32'd0;
    ill_pend  = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #1 check_reset_outs("async_reset_hold");
    @(negedge clk); #2;
    mem_ready = 1'b0;
    rst = 1'b1;
    run_instr(OP_R, 1, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_LW, 0, 1);
    run_instr(OP_R, 0, 0);

    @(negedge clk); #2;
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit (compared %0d)", n_cmp);
    $fatal(1);
  end

endmodule

`default_nettype wire
